// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: FSM state encoding for the command master,
// response codes and the default protection attribute. The slave register
// blocks import the same package so response codes agree across the fabric.
package axil_pkg;

    // Command master FSM states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,  // waiting for a command
        ST_WR   = 3'd1,  // AW and W channels in flight
        ST_WR_B = 3'd2,  // waiting for the write response
        ST_RD_A = 3'd3,  // AR channel in flight
        ST_RD_R = 3'd4,  // waiting for read data
        ST_RSP  = 3'd5   // presenting the result on the response stream
    } axil_state_e;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access.
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_watchdog.sv
// Cycle watchdog for the AXI-Lite command master. Counts enabled cycles since
// the last clear and raises expired on the TIMEOUT_CYCLES-th enabled cycle.
// Only instantiated when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count while enabled, restart on clear or when disabled, saturate at the limit.
    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/axil_master_cmd.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command stream.
// Each command becomes one AXI-Lite read or write; the result is returned on
// a valid/ready response stream. Commands are strictly serialised.
//
// Optional feature: define AXIL_MASTER_TIMEOUT_EN to add a watchdog that
// abandons a stuck transaction after TIMEOUT_CYCLES, returns SLVERR and sets
// the sticky timeout_err flag. With the feature, BREADY/RREADY stay high in
// IDLE so a late B/R beat from an abandoned transaction is drained.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where VALID and READY are both high; a VALID driven by this block is never
// withdrawn before its transfer (except on timeout recovery), and the
// response stream holds rsp_* stable while rsp_valid is high and rsp_ready low.
module axil_master_cmd
    import axil_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    // command stream
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    // response stream
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              timeout_err,
    // FSM state for observation
    output logic [2:0]                        dbg_state,
    // AXI4-Lite write address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    // AXI4-Lite write data
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    // AXI4-Lite write response
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    // AXI4-Lite read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    // AXI4-Lite read data
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam logic IDLE_SINK = 1'b1;
`else
    localparam logic IDLE_SINK = 1'b0;
`endif

    axil_state_e      state_q,     state_d;
    logic [AW-1:0]    addr_q,      addr_d;
    logic [DW-1:0]    wdata_q,     wdata_d;
    logic [SW-1:0]    wstrb_q,     wstrb_d;
    logic             write_q,     write_d;
    logic             awvalid_q,   awvalid_d;
    logic             wvalid_q,    wvalid_d;
    logic             aw_done_q,   aw_done_d;
    logic             w_done_q,    w_done_d;
    logic             bready_q,    bready_d;
    logic             arvalid_q,   arvalid_d;
    logic             rready_q,    rready_d;
    logic             rsp_write_q, rsp_write_d;
    logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [1:0]       rsp_resp_q,  rsp_resp_d;
    logic             tmo_err_q,   tmo_err_d;

    logic             aw_hs;
    logic             w_hs;
    logic             wd_expired;

    assign aw_hs = awvalid_q && M_AXI_AWREADY;
    assign w_hs  = wvalid_q  && M_AXI_WREADY;

`ifdef AXIL_MASTER_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;

    // The watchdog restarts on every state change and only runs while an AXI
    // transfer is outstanding.
    assign wd_clear  = (state_d != state_q);
    assign wd_enable = (state_q != ST_IDLE) && (state_q != ST_RSP);

    axil_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (M_AXI_ACLK),
        .rst_n   (M_AXI_ARESETN),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // Next-state and channel control for the single-outstanding transaction.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        tmo_err_d   = tmo_err_q;

        case (state_q)
            ST_IDLE: begin
                bready_d = IDLE_SINK;
                rready_d = IDLE_SINK;
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    wstrb_d  = cmd_wstrb;
                    write_d  = cmd_write;
                    bready_d = 1'b0;
                    rready_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = ST_RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end

            ST_WR: begin
                // AW and W complete independently, in any order.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d  = ST_WR_B;
                    bready_d = 1'b1;
                end
            end

            ST_WR_B: begin
                if (M_AXI_BVALID && bready_q) begin
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = M_AXI_BRESP;
                    bready_d    = 1'b0;
                    state_d     = ST_RSP;
                end
            end

            ST_RD_A: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_R;
                end
            end

            ST_RD_R: begin
                if (M_AXI_RVALID && rready_q) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    rready_d    = 1'b0;
                    state_d     = ST_RSP;
                end
            end

            ST_RSP: begin
                if (rsp_ready) begin
                    state_d  = ST_IDLE;
                    bready_d = IDLE_SINK;
                    rready_d = IDLE_SINK;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A real handshake in the expiry cycle wins; otherwise abandon the
        // transfer and report it as a slave error.
        if (wd_expired && (state_d == state_q)) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_write_d = write_q;
            rsp_rdata_d = '0;
            rsp_resp_d  = RESP_SLVERR;
            tmo_err_d   = 1'b1;
            state_d     = ST_RSP;
        end
    end

    // State and datapath registers; reset discards any in-flight command.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    // cmd_ready depends only on registered state (and reset), never on cmd_valid.
    assign cmd_ready   = (state_q == ST_IDLE) && M_AXI_ARESETN;
    assign rsp_valid   = (state_q == ST_RSP);
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign timeout_err = tmo_err_q;
    assign dbg_state   = state_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = PROT_DEFAULT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = PROT_DEFAULT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_master_cmd.sv
// Directed bench for axil_master_cmd with a delay-configurable AXI-Lite slave
// model, a channel monitor and a response scoreboard.
module tb_axil_master_cmd;

    localparam int AW = 12;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic aresetn;

    // ---------------- DUT signals ----------------
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout_err;
    logic [2:0]    dbg_state;
    logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
    logic          M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic [DW-1:0] M_AXI_WDATA;
    logic [3:0]    M_AXI_WSTRB;
    // slave-driven
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    axil_master_cmd #(
        .C_M_AXI_DATA_WIDTH (DW),
        .C_M_AXI_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .timeout_err   (timeout_err),
        .dbg_state     (dbg_state),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    // ---------------- slave configuration ----------------
    int         aw_delay, w_delay, b_delay, ar_delay, r_delay;
    logic [1:0] cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;

    // ---------------- monitor (samples on rising edge) ----------------
    int   cyc = 0;
    int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int   aw_hs_cyc, w_hs_cyc, b_hs_cyc, ar_hs_cyc, r_hs_cyc;
    bit   aw_hs_last, w_hs_last, b_hs_last, ar_hs_last, r_hs_last;
    bit   awv_pend, wv_pend, arv_pend;
    int   drop_viol = 0;
    int   rready_gap;
    logic [AW-1:0] mon_awaddr, mon_araddr;
    logic [DW-1:0] mon_wdata;
    logic [3:0]    mon_wstrb;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!aresetn) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_hs_last = 0; w_hs_last = 0; b_hs_last = 0; ar_hs_last = 0; r_hs_last = 0;
            awv_pend = 0; wv_pend = 0; arv_pend = 0;
            rready_gap = 0;
        end else begin
            if (awv_pend && !M_AXI_AWVALID) drop_viol++;
            if (wv_pend && !M_AXI_WVALID) drop_viol++;
            if (arv_pend && !M_AXI_ARVALID) drop_viol++;
            if (ar_cnt > r_cnt && !M_AXI_RREADY) rready_gap++;
            aw_hs_last = M_AXI_AWVALID && awready;
            w_hs_last  = M_AXI_WVALID && wready;
            b_hs_last  = bvalid && M_AXI_BREADY;
            ar_hs_last = M_AXI_ARVALID && arready;
            r_hs_last  = rvalid && M_AXI_RREADY;
            if (aw_hs_last) begin aw_cnt++; aw_hs_cyc = cyc; mon_awaddr = M_AXI_AWADDR; end
            if (w_hs_last) begin w_cnt++; w_hs_cyc = cyc; mon_wdata = M_AXI_WDATA; mon_wstrb = M_AXI_WSTRB; end
            if (b_hs_last) begin b_cnt++; b_hs_cyc = cyc; end
            if (ar_hs_last) begin ar_cnt++; ar_hs_cyc = cyc; mon_araddr = M_AXI_ARADDR; end
            if (r_hs_last) begin r_cnt++; r_hs_cyc = cyc; end
            awv_pend = M_AXI_AWVALID && !awready;
            wv_pend  = M_AXI_WVALID && !wready;
            arv_pend = M_AXI_ARVALID && !arready;
        end
    end

    // ---------------- slave model (drives on falling edge) ----------------
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;

    initial begin
        awready = 0; aw_wait = 0;
        forever begin
            @(negedge clk);
            if (!aresetn || aw_hs_last) begin awready = 0; aw_wait = 0; end
            else if (!M_AXI_AWVALID) aw_wait = 0;
            else if (!awready) begin
                if (aw_wait >= aw_delay) awready = 1; else aw_wait++;
            end
        end
    end

    initial begin
        wready = 0; w_wait = 0;
        forever begin
            @(negedge clk);
            if (!aresetn || w_hs_last) begin wready = 0; w_wait = 0; end
            else if (!M_AXI_WVALID) w_wait = 0;
            else if (!wready) begin
                if (w_wait >= w_delay) wready = 1; else w_wait++;
            end
        end
    end

    initial begin
        bvalid = 0; bresp = 0; b_wait = 0;
        forever begin
            @(negedge clk);
            if (!aresetn || b_hs_last) begin bvalid = 0; bresp = 0; b_wait = 0; end
            else if (!bvalid && aw_cnt > b_cnt && w_cnt > b_cnt) begin
                if (b_wait >= b_delay) begin bvalid = 1; bresp = cfg_bresp; end
                else b_wait++;
            end
        end
    end

    initial begin
        arready = 0; ar_wait = 0;
        forever begin
            @(negedge clk);
            if (!aresetn || ar_hs_last) begin arready = 0; ar_wait = 0; end
            else if (!M_AXI_ARVALID) ar_wait = 0;
            else if (!arready) begin
                if (ar_wait >= ar_delay) arready = 1; else ar_wait++;
            end
        end
    end

    initial begin
        rvalid = 0; rdata = 0; rresp = 0; r_wait = 0;
        forever begin
            @(negedge clk);
            if (!aresetn || r_hs_last) begin rvalid = 0; rdata = 0; rresp = 0; r_wait = 0; end
            else if (!rvalid && ar_cnt > r_cnt) begin
                if (r_wait >= r_delay) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; end
                else r_wait++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    // entry = {write, rdata, resp}
    logic [34:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int accept_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic [3:0] strb, input logic [DW-1:0] exp_rdata,
                            input logic [1:0] exp_resp);
        int budget;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (cmd_ready !== 1'b1) begin
            check("cmd_accept_bound", 64'd0, 64'd1);
            cmd_valid = 0;
        end else begin
            accept_cyc = cyc + 1;
            exp_q.push_back({wr, exp_rdata, exp_resp});
            @(negedge clk);
            cmd_valid = 0;
        end
    endtask

    // Wait for a response, compare it, optionally stall, then consume it.
    task automatic wait_rsp(input int stall, output int rsp_cyc);
        int budget;
        logic [34:0] e;
        budget = 0;
        rsp_cyc = 0;
        while (rsp_valid !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (rsp_valid !== 1'b1) begin
            check("rsp_wait_bound", 64'd0, 64'd1);
        end else if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
            rsp_cyc = cyc + 1;
            e = exp_q.pop_front();
            check("rsp_write", 64'(rsp_write), 64'(e[34]));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e[33:2]));
            check("rsp_resp", 64'(rsp_resp), 64'(e[1:0]));
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
                check("stall_rsp_resp", 64'(rsp_resp), 64'(e[1:0]));
                check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
                check("stall_axi_quiet", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                                              M_AXI_BREADY, M_AXI_RREADY}), 64'd0);
            end
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
            check("rsp_consumed", 64'({rsp_valid, cmd_ready}), 64'b01);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 64'({cmd_ready, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                   M_AXI_ARVALID, M_AXI_RREADY, timeout_err}), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
        check({tag, "_rsp"}, 64'({rsp_write, rsp_rdata, rsp_resp}), 64'd0);
        check({tag, "_addr_data"}, 64'({M_AXI_AWADDR, M_AXI_WDATA}), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rc, n, aw0, w0, b0, ar0;
        aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        aresetn = 1;
        @(negedge clk);

        // 1: zero-wait write, latency T1/T2/T3
        send_cmd(1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
        wait_rsp(0, rc);
        check("wr_aw_latency", 64'(aw_hs_cyc - accept_cyc), 64'd1);
        check("wr_w_latency", 64'(w_hs_cyc - accept_cyc), 64'd1);
        check("wr_b_latency", 64'(b_hs_cyc - accept_cyc), 64'd2);
        check("wr_rsp_latency", 64'(rc - accept_cyc), 64'd3);
        check("wr_awaddr", 64'(mon_awaddr), 64'h008);
        check("wr_wdata", 64'(mon_wdata), 64'hDEADBEEF);
        check("wr_wstrb", 64'(mon_wstrb), 64'hF);
        check("prot", 64'({M_AXI_AWPROT, M_AXI_ARPROT}), 64'd0);

        // 2: read with 5 wait cycles on RVALID
        r_delay = 5; cfg_rdata = 32'h12345678; cfg_rresp = 2'b00;
        send_cmd(1'b0, 12'h004, 32'h0, 4'h0, 32'h12345678, 2'b00);
        wait_rsp(0, rc);
        check("rd_araddr", 64'(mon_araddr), 64'h004);
        check("rd_r_wait", 64'(r_hs_cyc - ar_hs_cyc), 64'd6);
        check("rd_rready_held", 64'(rready_gap), 64'd0);
        r_delay = 0;

        // 3: WREADY three cycles before AWREADY
        aw_delay = 3; aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        send_cmd(1'b1, 12'h00C, 32'hCAFEF00D, 4'h3, 32'h0, 2'b00);
        wait_rsp(0, rc);
        check("split_w_latency", 64'(w_hs_cyc - accept_cyc), 64'd1);
        check("split_aw_latency", 64'(aw_hs_cyc - accept_cyc), 64'd4);
        check("split_counts", 64'({8'(aw_cnt - aw0), 8'(w_cnt - w0), 8'(b_cnt - b0)}), 64'h010101);
        check("split_wdata", 64'({mon_wstrb, mon_wdata}), 64'h3CAFEF00D);
        check("valid_never_dropped", 64'(drop_viol), 64'd0);
        aw_delay = 0;

        // 4: DECERR pass-through with response back-pressure
        cfg_bresp = 2'b11; aw0 = aw_cnt; ar0 = ar_cnt;
        send_cmd(1'b1, 12'h010, 32'h00000001, 4'hF, 32'h0, 2'b11);
        wait_rsp(10, rc);
        check("stall_no_new_aw", 64'(aw_cnt - aw0), 64'd1);
        check("stall_no_new_ar", 64'(ar_cnt - ar0), 64'd0);
        cfg_bresp = 2'b00;

        // 5: reset while waiting for B
        b_delay = 20;
        send_cmd(1'b1, 12'h014, 32'h55AA55AA, 4'hF, 32'h0, 2'b00);
        n = 0;
        while (dbg_state !== 3'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_wr_b", 64'(dbg_state), 64'd2);
        aresetn = 0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        void'(exp_q.pop_back());
        @(negedge clk);
        aresetn = 1; b_delay = 0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_no_rsp", 64'({rsp_valid, cmd_ready}), 64'b01);
        end

        // 6: zero-wait read after reset, SLVERR pass-through
        cfg_rdata = 32'hA5A50001; cfg_rresp = 2'b10;
        send_cmd(1'b0, 12'h018, 32'h0, 4'h0, 32'hA5A50001, 2'b10);
        wait_rsp(0, rc);
        check("rd_rsp_latency", 64'(rc - accept_cyc), 64'd3);
        check("rd2_araddr", 64'(mon_araddr), 64'h018);
        check("rd2_r_latency", 64'(r_hs_cyc - accept_cyc), 64'd2);
        cfg_rresp = 2'b00;

`ifdef AXIL_MASTER_TIMEOUT_EN
        // 7: ARREADY never arrives, watchdog of 16 cycles
        ar_delay = 1000;
        send_cmd(1'b0, 12'h01C, 32'h0, 4'h0, 32'h0, 2'b10);
        n = 0;
        while (M_AXI_ARVALID === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("tmo_arvalid_cycles", 64'(n), 64'd16);
        wait_rsp(0, rc);
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", 64'(timeout_err), 64'd1);
        ar_delay = 0;
        aresetn = 0;
        @(negedge clk);
        check("tmo_err_cleared", 64'(timeout_err), 64'd0);
        aresetn = 1;
        @(negedge clk);
`else
        check("timeout_err_tied", 64'(timeout_err), 64'd0);
`endif

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
